// File: rtl/msu_stream_ctrl.sv
// msu_stream_ctrl: AXI-stream job controller for the modular-squaring unit.
// Iterates an external squarer from t_start to t_final, emitting checkpoint frames.
module msu_stream_ctrl #(
  parameter int AXI_LEN           = 32,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int MOD_LEN           = 1024,
  parameter int T_LEN             = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [AXI_LEN-1:0]           s_axis_tdata,
  input  logic                         s_axis_tlast,
  output logic [C_XFER_SIZE_WIDTH-1:0] s_axis_xfer_size_in_bytes,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [AXI_LEN-1:0]           m_axis_tdata,
  output logic [AXI_LEN/8-1:0]         m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic [C_XFER_SIZE_WIDTH-1:0] m_axis_xfer_size_in_bytes,
  input  logic                         ap_start,
  input  logic                         abort,
  output logic                         ap_done,
  output logic [1:0]                   status,
  output logic                         start_xfer,
  output logic                         sq_valid_in,
  output logic [MOD_LEN-1:0]           sq_in,
  input  logic                         sq_valid_out,
  input  logic [MOD_LEN-1:0]           sq_out
);

  localparam int IN_COUNT  = 3*T_LEN/AXI_LEN + MOD_LEN/AXI_LEN;
  localparam int OUT_COUNT = T_LEN/AXI_LEN + MOD_LEN/AXI_LEN;
  localparam int IN_W      = IN_COUNT*AXI_LEN;
  localparam int CW        = $clog2(IN_COUNT+1);
  localparam logic [CW-1:0] IN_LAST  = CW'(IN_COUNT-1);
  localparam logic [CW-1:0] OUT_LAST = CW'(OUT_COUNT-1);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_DRAIN, S_LOAD,
    S_ISSUE, S_WAIT, S_SEND, S_DONE
  } state_t;

  state_t               state, nxt;
  logic [IN_W-1:0]      in_buf;
  logic [CW-1:0]        beat_cnt, out_cnt;
  logic [T_LEN-1:0]     t_cur, ckpt_cnt;
  logic [MOD_LEN-1:0]   op;
  logic                 abort_q, final_q, fin;
  logic [1:0]           status_q, code;

  logic [T_LEN-1:0]     t_start, t_final, t_ckpt;
  logic [T_LEN-1:0]     t_nxt, ck_nxt;
  logic [MOD_LEN-1:0]   value;
  logic                 in_beat, out_beat;
  logic                 abort_ok, abort_req, ck_hit;
  logic [MOD_LEN+T_LEN-1:0] out_word;

  assign t_start  = in_buf[T_LEN-1:0];
  assign t_final  = in_buf[2*T_LEN-1:T_LEN];
  assign t_ckpt   = in_buf[3*T_LEN-1:2*T_LEN];
  assign value    = in_buf[3*T_LEN +: MOD_LEN];
  assign in_beat  = s_axis_tvalid && s_axis_tready;
  assign out_beat = m_axis_tvalid && m_axis_tready;
  assign t_nxt    = t_cur + T_LEN'(1);
  assign ck_nxt   = (t_ckpt != '0) ? ckpt_cnt - T_LEN'(1) : ckpt_cnt;
  assign ck_hit   = (t_ckpt != '0) && (ck_nxt == '0);
  assign out_word = {op, t_cur};
  assign abort_ok = abort && (state == S_RECV || state == S_DRAIN ||
                              state == S_ISSUE || state == S_WAIT ||
                              state == S_SEND);
  assign abort_req = abort_q || abort_ok;

  // State register plus job datapath (input buffer, counters, operand)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      in_buf   <= '0;
      beat_cnt <= '0;
      out_cnt  <= '0;
      t_cur    <= '0;
      ckpt_cnt <= '0;
      op       <= '0;
      abort_q  <= 1'b0;
      final_q  <= 1'b0;
      status_q <= 2'd0;
    end else begin
      state   <= nxt;
      final_q <= fin;
      if (nxt == S_IDLE)
        abort_q <= 1'b0;
      else if (abort_ok)
        abort_q <= 1'b1;
      if (state == S_IDLE && ap_start)
        status_q <= 2'd0;
      else if (nxt == S_DONE)
        status_q <= code;
      if (state == S_IDLE)
        beat_cnt <= '0;
      else if (state == S_RECV && in_beat) begin
        in_buf   <= {s_axis_tdata, in_buf[IN_W-1:AXI_LEN]};
        beat_cnt <= beat_cnt + CW'(1);
      end
      if (state != S_SEND)
        out_cnt <= '0;
      else if (out_beat)
        out_cnt <= m_axis_tlast ? '0 : out_cnt + CW'(1);
      if (state == S_LOAD) begin
        t_cur    <= t_start;
        op       <= value;
        ckpt_cnt <= t_ckpt;
      end else if (state == S_WAIT && sq_valid_out) begin
        t_cur    <= t_nxt;
        op       <= sq_out;
        ckpt_cnt <= ck_hit ? t_ckpt : ck_nxt;
      end
    end
  end

  // Next-state decision with completion code and final-frame flag
  always_comb begin
    nxt  = state;
    code = status_q;
    fin  = final_q;
    unique case (state)
      S_IDLE:
        if (ap_start) nxt = S_RECV;
      S_RECV:
        if (in_beat && s_axis_tlast) begin
          if (abort_req) begin
            nxt = S_DONE; code = 2'd2;
          end else if (beat_cnt == IN_LAST)
            nxt = S_LOAD;
          else begin
            nxt = S_DONE; code = 2'd1;
          end
        end else if (abort_req || (in_beat && beat_cnt == IN_LAST))
          nxt = S_DRAIN;
      S_DRAIN:
        if (in_beat && s_axis_tlast) begin
          nxt  = S_DONE;
          code = abort_req ? 2'd2 : 2'd1;
        end
      S_LOAD:
        if (t_final < t_start) begin
          nxt = S_DONE; code = 2'd1;
        end else if (t_final == t_start) begin
          nxt = S_SEND; fin = 1'b1;
        end else
          nxt = S_ISSUE;
      S_ISSUE:
        nxt = S_WAIT;
      S_WAIT:
        if (sq_valid_out) begin
          if (t_nxt == t_final) begin
            nxt = S_SEND; fin = 1'b1;
          end else if (abort_req) begin
            nxt = S_DONE; code = 2'd2;
          end else if (ck_hit) begin
            nxt = S_SEND; fin = 1'b0;
          end else
            nxt = S_ISSUE;
        end
      S_SEND:
        if (out_beat && m_axis_tlast) begin
          if (final_q) begin
            nxt = S_DONE; code = 2'd0;
          end else if (abort_req) begin
            nxt = S_DONE; code = 2'd2;
          end else
            nxt = S_ISSUE;
        end
      S_DONE:
        nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
  end

  // Stream, squarer and completion outputs decoded from state
  always_comb begin
    s_axis_tready = (state == S_RECV) || (state == S_DRAIN);
    m_axis_tvalid = (state == S_SEND);
    m_axis_tlast  = (state == S_SEND) && (out_cnt == OUT_LAST);
    m_axis_tdata  = '0;
    if (state == S_SEND)
      for (int i = 0; i < OUT_COUNT; i++)
        if (out_cnt == CW'(i))
          m_axis_tdata = out_word[i*AXI_LEN +: AXI_LEN];
    m_axis_tkeep  = '1;
    start_xfer    = (nxt == S_SEND) && (state != S_SEND);
    sq_valid_in   = (state == S_ISSUE);
    sq_in         = op;
    ap_done       = (state == S_DONE);
    status        = status_q;
    s_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(IN_COUNT*AXI_LEN/8);
    m_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(OUT_COUNT*AXI_LEN/8);
  end

endmodule

// File: tb/tb_msu_stream_ctrl.sv
// tb_msu_stream_ctrl: scoreboard bench for msu_stream_ctrl.
// Squarer model is x*x; expected beats and statuses are queued at stimulus time.
module tb_msu_stream_ctrl;

  localparam int AXI_LEN   = 32;
  localparam int XW        = 32;
  localparam int MOD_LEN   = 1024;
  localparam int T_LEN     = 64;
  localparam int IN_COUNT  = 3*T_LEN/AXI_LEN + MOD_LEN/AXI_LEN;
  localparam int OUT_COUNT = T_LEN/AXI_LEN + MOD_LEN/AXI_LEN;
  localparam int IN_W      = IN_COUNT*AXI_LEN;
  localparam int OUT_W     = OUT_COUNT*AXI_LEN;

  typedef struct {
    logic [AXI_LEN-1:0] d;
    logic               l;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tready;
  logic [AXI_LEN-1:0]   s_axis_tdata = '0;
  logic                 s_axis_tlast = 1'b0;
  logic [XW-1:0]        s_axis_xfer_size_in_bytes;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready = 1'b1;
  logic [AXI_LEN-1:0]   m_axis_tdata;
  logic [AXI_LEN/8-1:0] m_axis_tkeep;
  logic                 m_axis_tlast;
  logic [XW-1:0]        m_axis_xfer_size_in_bytes;
  logic                 ap_start = 1'b0;
  logic                 abort = 1'b0;
  logic                 ap_done;
  logic [1:0]           status;
  logic                 start_xfer;
  logic                 sq_valid_in;
  logic [MOD_LEN-1:0]   sq_in;
  logic                 sq_valid_out = 1'b0;
  logic [MOD_LEN-1:0]   sq_out = '0;

  beat_t      exp_q[$];
  logic [1:0] st_q[$];
  int n_chk = 0, n_pass = 0;
  int n_issue = 0, n_start = 0, beats_seen = 0;
  int fixed_lat = 0;
  bit stall_en = 0;
  bit start_prev = 0;

  msu_stream_ctrl #(
    .AXI_LEN(AXI_LEN), .C_XFER_SIZE_WIDTH(XW),
    .MOD_LEN(MOD_LEN), .T_LEN(T_LEN)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_xfer_size_in_bytes(s_axis_xfer_size_in_bytes),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_xfer_size_in_bytes(m_axis_xfer_size_in_bytes),
    .ap_start(ap_start), .abort(abort), .ap_done(ap_done),
    .status(status), .start_xfer(start_xfer),
    .sq_valid_in(sq_valid_in), .sq_in(sq_in),
    .sq_valid_out(sq_valid_out), .sq_out(sq_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push_frame(input logic [63:0] t,
                            input logic [MOD_LEN-1:0] x);
    logic [OUT_W-1:0] w;
    beat_t b;
    w = {x, t};
    for (int i = 0; i < OUT_COUNT; i++) begin
      b.d = w[i*AXI_LEN +: AXI_LEN];
      b.l = (i == OUT_COUNT-1);
      exp_q.push_back(b);
    end
  endtask

  task automatic model_job(input logic [63:0] ts, input logic [63:0] tf,
                           input logic [63:0] tc,
                           input logic [MOD_LEN-1:0] v);
    logic [63:0] t;
    logic [MOD_LEN-1:0] x;
    if (tf < ts) begin
      st_q.push_back(2'd1);
      return;
    end
    t = ts;
    x = v;
    while (t != tf) begin
      x = x * x;
      t = t + 64'd1;
      if (tc != 0 && t != tf && ((t - ts) % tc) == 0)
        push_frame(t, x);
    end
    push_frame(t, x);
    st_q.push_back(2'd0);
  endtask

  task automatic run_job(input logic [63:0] ts, input logic [63:0] tf,
                         input logic [63:0] tc,
                         input logic [MOD_LEN-1:0] v,
                         input int nb, input int last_idx);
    logic [IN_W-1:0] w;
    int n;
    w = {v, tc, tf, ts};
    @(posedge clk); #1 ap_start = 1'b1;
    @(posedge clk); #1 ap_start = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i < IN_COUNT) s_axis_tdata = w[i*AXI_LEN +: AXI_LEN];
      else s_axis_tdata = $urandom;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == last_idx);
      n = 0;
      forever begin
        @(negedge clk);
        if (s_axis_tready || n >= 200) break;
        n++;
      end
      if (n >= 200) chk("in_timeout", {63'd0, s_axis_tready}, 64'd1);
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || st_q.size() != 0) && n < bound) begin
      @(posedge clk);
      n++;
    end
    chk("timeout", 64'(exp_q.size() + st_q.size()), 64'd0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats_seen < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beat_wait", 64'(beats_seen >= target), 64'd1);
  endtask

  // squarer model: result x*x after 1..4 cycles
  initial forever begin
    int lat;
    logic [MOD_LEN-1:0] x;
    @(negedge clk);
    if (reset && sq_valid_in) begin
      n_issue++;
      x = sq_in;
      lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
      repeat (lat) @(posedge clk);
      #1 sq_out = x * x; sq_valid_out = 1'b1;
      @(posedge clk);
      #1 sq_valid_out = 1'b0;
    end
  end

  // downstream backpressure
  initial forever begin
    @(posedge clk);
    #1 m_axis_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // output monitor and scoreboard compare
  always @(negedge clk) begin
    beat_t b;
    if (reset) begin
      if (start_prev) chk("start_lead", {63'd0, m_axis_tvalid}, 64'd1);
      start_prev = start_xfer;
      if (start_xfer) n_start++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0)
          chk("beat_unexp", {63'd0, m_axis_tvalid}, 64'd0);
        else begin
          b = exp_q.pop_front();
          chk("tdata", 64'(m_axis_tdata), 64'(b.d));
          chk("tlast", {63'd0, m_axis_tlast}, {63'd0, b.l});
        end
        beats_seen++;
      end
      if (ap_done) begin
        if (st_q.size() == 0)
          chk("done_unexp", {63'd0, ap_done}, 64'd0);
        else
          chk("status", 64'(status), 64'(st_q.pop_front()));
      end
    end else
      start_prev = 0;
  end

  initial begin
    int base_i, base_s, base_b;
    logic [MOD_LEN-1:0] v7;
    repeat (3) @(negedge clk);
    chk("rst_tready", {63'd0, s_axis_tready}, 64'd0);
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_done", {63'd0, ap_done}, 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_sqv", {63'd0, sq_valid_in}, 64'd0);
    chk("rst_start", {63'd0, start_xfer}, 64'd0);
    chk("tkeep", 64'(m_axis_tkeep), 64'hf);
    chk("s_xfer", 64'(s_axis_xfer_size_in_bytes), 64'd152);
    chk("m_xfer", 64'(m_axis_xfer_size_in_bytes), 64'd136);
    reset = 1'b1;

    // nominal: 2 -> 256 after 3 squarings
    base_i = n_issue; base_s = n_start;
    model_job(0, 3, 0, 2);
    run_job(0, 3, 0, 2, IN_COUNT, IN_COUNT-1);
    drain(2000);
    chk("nom_issues", 64'(n_issue - base_i), 64'd3);
    chk("nom_frames", 64'(n_start - base_s), 64'd1);
    chk("nom_status_hold", 64'(status), 64'd0);

    // checkpoints at t=2,4 plus final t=5, with stalls
    stall_en = 1;
    base_s = n_start;
    model_job(0, 5, 2, 2);
    run_job(0, 5, 2, 2, IN_COUNT, IN_COUNT-1);
    drain(5000);
    chk("ckpt_frames", 64'(n_start - base_s), 64'd3);
    stall_en = 0;

    // short frame
    base_s = n_start;
    st_q.push_back(2'd1);
    run_job(0, 3, 0, 2, 11, 10);
    drain(500);
    chk("short_frames", 64'(n_start - base_s), 64'd0);

    // long frame, extra beats drained
    base_s = n_start;
    st_q.push_back(2'd1);
    run_job(0, 3, 0, 2, 40, 39);
    drain(500);
    chk("long_frames", 64'(n_start - base_s), 64'd0);

    // t_final == t_start: immediate frame, no squaring
    v7 = {32'hdead_beef, 64'h0123_4567_89ab_cdef};
    base_i = n_issue;
    model_job(7, 7, 0, v7);
    run_job(7, 7, 0, v7, IN_COUNT, IN_COUNT-1);
    drain(500);
    chk("eq_issues", 64'(n_issue - base_i), 64'd0);

    // t_final < t_start
    model_job(9, 4, 0, 5);
    run_job(9, 4, 0, 5, IN_COUNT, IN_COUNT-1);
    drain(500);

    // abort during WAIT at t=1
    fixed_lat = 3;
    base_i = n_issue;
    st_q.push_back(2'd2);
    run_job(0, 100, 0, 2, IN_COUNT, IN_COUNT-1);
    for (int n = 0; n < 200 && n_issue < base_i + 2; n++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    drain(500);
    chk("abort_issues", 64'(n_issue - base_i), 64'd2);
    fixed_lat = 0;

    // abort during a checkpoint frame
    base_b = beats_seen; base_s = n_start;
    push_frame(2, 16);
    st_q.push_back(2'd2);
    run_job(0, 20, 2, 2, IN_COUNT, IN_COUNT-1);
    wait_beats(base_b + 3);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    drain(2000);
    chk("abort_send_frames", 64'(n_start - base_s), 64'd1);

    // async reset mid-frame at beat 5
    base_b = beats_seen;
    model_job(7, 7, 0, v7);
    run_job(7, 7, 0, v7, IN_COUNT, IN_COUNT-1);
    wait_beats(base_b + 5);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_mid_done", {63'd0, ap_done}, 64'd0);
    chk("rst_mid_status", 64'(status), 64'd0);
    exp_q.delete();
    st_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // fresh job after reset
    base_s = n_start;
    model_job(0, 3, 0, 3);
    run_job(0, 3, 0, 3, IN_COUNT, IN_COUNT-1);
    drain(2000);
    chk("post_rst_frames", 64'(n_start - base_s), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
